// File: rtl/seg_scan_display_pkg.sv
// Shared constants for the seven-segment scan display: active-low segment
// patterns {dp,g,f,e,d,c,b,a} and the all-off digit select.
package seg_scan_display_pkg;

    localparam logic [7:0] SEG_0    = 8'hC0;
    localparam logic [7:0] SEG_1    = 8'hF9;
    localparam logic [7:0] SEG_2    = 8'hA4;
    localparam logic [7:0] SEG_3    = 8'hB0;
    localparam logic [7:0] SEG_4    = 8'h99;
    localparam logic [7:0] SEG_5    = 8'h92;
    localparam logic [7:0] SEG_6    = 8'h82;
    localparam logic [7:0] SEG_7    = 8'hF8;
    localparam logic [7:0] SEG_8    = 8'h80;
    localparam logic [7:0] SEG_9    = 8'h90;
    localparam logic [7:0] SEG_DASH = 8'hBF;
    localparam logic [7:0] SEG_OFF  = 8'hFF;
    localparam logic [5:0] SEL_OFF  = 6'h3F;

endpackage

// File: rtl/seg_scan_display_seg7_decode.sv
// Combinational digit-to-segment decoder (active low, dp excluded).
// Any value outside 0..9 decodes to a dash.
module seg7_decode
    import seg_scan_display_pkg::*;
(
    input  logic [5:0] digit,
    output logic [6:0] pattern
);

    // Map a BCD digit onto its g..a pattern
    always_comb begin
        pattern = SEG_DASH[6:0];
        case (digit)
            6'd0:    pattern = SEG_0[6:0];
            6'd1:    pattern = SEG_1[6:0];
            6'd2:    pattern = SEG_2[6:0];
            6'd3:    pattern = SEG_3[6:0];
            6'd4:    pattern = SEG_4[6:0];
            6'd5:    pattern = SEG_5[6:0];
            6'd6:    pattern = SEG_6[6:0];
            6'd7:    pattern = SEG_7[6:0];
            6'd8:    pattern = SEG_8[6:0];
            6'd9:    pattern = SEG_9[6:0];
            default: pattern = SEG_DASH[6:0];
        endcase
    end

endmodule

// File: rtl/seg_scan_display.sv
// Six-digit multiplexed time display with per-slot blanking, frame snapshot
// and blinking separators. Optional macro: LEADING_ZERO_BLANK_EN.
module seg_scan_display
    import seg_scan_display_pkg::*;
#(
    parameter int SCAN_DIV   = 2,
    parameter int BLINK_HALF = 500
) (
    input  logic       clk1,
    input  logic       rst_n,
    input  logic [5:0] op0,
    input  logic [5:0] op1,
    input  logic [5:0] op2,
    input  logic [5:0] op3,
    input  logic [5:0] op4,
    input  logic [5:0] op5,
    output logic [5:0] sel,
    output logic [7:0] seg
);

    localparam logic [7:0] PHASE_LAST = 8'(SCAN_DIV - 1);
    localparam logic [9:0] BLINK_LAST = 10'(BLINK_HALF - 1);

    logic [2:0] slot_r;
    logic [7:0] phase_r;
    logic [5:0] snap_r [6];
    logic [9:0] blink_cnt_r;
    logic       blink_r;

    logic [5:0] cur_digit_s;
    logic [6:0] pattern_s;
    logic       lz_blank_s;
    logic       dp_on_s;
    logic [5:0] sel_s;
    logic [7:0] seg_s;

    // Select the snapshot digit belonging to the current slot
    always_comb begin
        cur_digit_s = snap_r[0];
        case (slot_r)
            3'd0:    cur_digit_s = snap_r[0];
            3'd1:    cur_digit_s = snap_r[1];
            3'd2:    cur_digit_s = snap_r[2];
            3'd3:    cur_digit_s = snap_r[3];
            3'd4:    cur_digit_s = snap_r[4];
            3'd5:    cur_digit_s = snap_r[5];
            default: cur_digit_s = snap_r[0];
        endcase
    end

    seg7_decode u_decode (
        .digit   (cur_digit_s),
        .pattern (pattern_s)
    );

    // Compute the next sel/seg from the counters; the first cycle of a slot is blank
    always_comb begin
        sel_s      = SEL_OFF;
        seg_s      = SEG_OFF;
`ifdef LEADING_ZERO_BLANK_EN
        lz_blank_s = (slot_r == 3'd5) && (snap_r[5] == 6'd0);
`else
        lz_blank_s = 1'b0;
`endif
        dp_on_s    = blink_r && ((slot_r == 3'd2) || (slot_r == 3'd4));
        if (phase_r == 8'd0 || lz_blank_s) begin
            sel_s = SEL_OFF;
            seg_s = SEG_OFF;
        end else begin
            sel_s = ~(6'b000001 << slot_r);
            seg_s = {~dp_on_s, pattern_s};
        end
    end

    // Slot/phase scan counters; slot 5 rolls straight into slot 0
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            slot_r  <= 3'd0;
            phase_r <= 8'd0;
        end else if (phase_r == PHASE_LAST) begin
            phase_r <= 8'd0;
            slot_r  <= (slot_r == 3'd5) ? 3'd0 : slot_r + 3'd1;
        end else begin
            phase_r <= phase_r + 8'd1;
        end
    end

    // Capture all inputs on the edge that enters slot 0 so a frame never tears
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 6; i++) snap_r[i] <= 6'd0;
        end else if (slot_r == 3'd0 && phase_r == 8'd0) begin
            snap_r[0] <= op0;
            snap_r[1] <= op1;
            snap_r[2] <= op2;
            snap_r[3] <= op3;
            snap_r[4] <= op4;
            snap_r[5] <= op5;
        end else begin
            snap_r <= snap_r;
        end
    end

    // Free-running separator blink
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_r <= 10'd0;
            blink_r     <= 1'b0;
        end else if (blink_cnt_r == BLINK_LAST) begin
            blink_cnt_r <= 10'd0;
            blink_r     <= ~blink_r;
        end else begin
            blink_cnt_r <= blink_cnt_r + 10'd1;
        end
    end

    // Registered display outputs
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            sel <= SEL_OFF;
            seg <= SEG_OFF;
        end else begin
            sel <= sel_s;
            seg <= seg_s;
        end
    end

endmodule

// File: tb/tb_seg_scan_display.sv
// Scoreboard bench for seg_scan_display (SCAN_DIV=2, BLINK_HALF=4); honours
// LEADING_ZERO_BLANK_EN when the same define is given to the bench.
module tb_seg_scan_display;

    localparam int SD = 2;
    localparam int BH = 4;

    logic       clk1  = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] op [6];
    logic [5:0] sel;
    logic [7:0] seg;

    always #5 clk1 = ~clk1;

    seg_scan_display #(.SCAN_DIV(SD), .BLINK_HALF(BH)) dut (
        .clk1  (clk1),
        .rst_n (rst_n),
        .op0   (op[0]),
        .op1   (op[1]),
        .op2   (op[2]),
        .op3   (op[3]),
        .op4   (op[4]),
        .op5   (op[5]),
        .sel   (sel),
        .seg   (seg)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic [13:0] exp_q [$];

    int          m_slot, m_phase, m_bc;
    logic        m_blk;
    logic [5:0]  m_snap [6];

    function automatic logic [7:0] pat(input logic [5:0] d);
        case (d)
            6'd0:    return 8'hC0;
            6'd1:    return 8'hF9;
            6'd2:    return 8'hA4;
            6'd3:    return 8'hB0;
            6'd4:    return 8'h99;
            6'd5:    return 8'h92;
            6'd6:    return 8'h82;
            6'd7:    return 8'hF8;
            6'd8:    return 8'h80;
            6'd9:    return 8'h90;
            default: return 8'hBF;
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_slot  = 0;
        m_phase = 0;
        m_bc    = 0;
        m_blk   = 1'b0;
        for (int i = 0; i < 6; i++) m_snap[i] = 6'd0;
        exp_q.delete();
    endtask

    // Predict the output of the coming edge, advance the model, then compare
    task automatic step();
        logic [5:0]  es;
        logic [7:0]  eg;
        logic [13:0] e;
        logic        lz;
        es = 6'h3F;
        eg = 8'hFF;
        lz = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        lz = (m_slot == 5) && (m_snap[5] == 6'd0);
`endif
        if (m_phase != 0 && !lz) begin
            es = ~(6'b000001 << m_slot);
            eg = pat(m_snap[m_slot]);
            if (m_blk && (m_slot == 2 || m_slot == 4)) eg[7] = 1'b0;
        end
        exp_q.push_back({es, eg});
        if (m_slot == 0 && m_phase == 0) begin
            for (int i = 0; i < 6; i++) m_snap[i] = op[i];
        end
        if (m_phase == SD - 1) begin
            m_phase = 0;
            m_slot  = (m_slot == 5) ? 0 : m_slot + 1;
        end else begin
            m_phase++;
        end
        if (m_bc == BH - 1) begin
            m_bc  = 0;
            m_blk = ~m_blk;
        end else begin
            m_bc++;
        end
        @(posedge clk1);
        #1;
        cyc++;
        if (exp_q.size() == 0) begin
            check_eq("queue_empty", 8'd1, 8'd0);
        end else begin
            e = exp_q.pop_front();
            check_eq("sel", {2'b00, sel}, {2'b00, e[13:8]});
            check_eq("seg", seg, e[7:0]);
        end
    endtask

    initial begin
        for (int i = 0; i < 6; i++) op[i] = 6'd0;
        model_reset();
        repeat (2) @(posedge clk1);
        #1;
        check_eq("rst_sel", {2'b00, sel}, 8'h3F);
        check_eq("rst_seg", seg, 8'hFF);

        // op5..op0 = 1..6
        for (int i = 0; i < 6; i++) op[i] = 6'(6 - i);
        @(negedge clk1);
        rst_n = 1'b1;
        model_reset();
        repeat (24) step();

        op[0] = 6'd12;
        repeat (24) step();

        op[0] = 6'd3;
        repeat (12) step();
        for (int k = 0; k < 20 && m_slot != 3; k++) step();
        op[0] = 6'd7;
        repeat (24) step();

        op[5] = 6'd0;
        repeat (36) step();

        for (int k = 0; k < 120; k++) begin
            if (k % 5 == 0) op[$urandom_range(0, 5)] = 6'($urandom_range(0, 63));
            step();
        end

        // Asynchronous reset while a digit is lit
        op[5] = 6'd8;
        repeat (12) step();
        for (int k = 0; k < 4 && m_phase != 0; k++) step();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_sel", {2'b00, sel}, 8'h3F);
        check_eq("async_rst_seg", seg, 8'hFF);
        @(negedge clk1);
        rst_n = 1'b1;
        model_reset();
        repeat (24) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_scan_display.md
SEG_SCAN_DISPLAY -- requirements
Module: seg_scan_display

Interface
REQ-001 Parameter SCAN_DIV, default 2: clk1 cycles per digit slot; legal range 2..255.
REQ-002 Parameter BLINK_HALF, default 500: clk1 cycles per half-period of the separator blink, giving 1 Hz at 1 kHz; legal range 1..1023.
REQ-003 Port clk1, input, 1 bit: the single clock, 1 kHz divided clock; all logic SHALL be on its rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Ports op0..op5, input, 6 bits each: time digits; op0 = seconds units … op5 = hours tens; legal values 0..9.
REQ-006 Port sel, output, 6 bits: digit enables, active low; sel[k] drives digit k, showing opk.
REQ-007 Port seg, output, 8 bits: segments, active low; seg[7] = dp, seg[6:0] = g,f,e,d,c,b,a.

Function
REQ-008 The block SHALL scan slots 0,1,2,3,4,5,0,… with each slot lasting exactly SCAN_DIV clk1 cycles.
REQ-009 In the first cycle of every slot, sel SHALL be 6'h3F and seg SHALL be 8'hFF (anti-ghost blanking).
REQ-010 In the remaining SCAN_DIV-1 cycles of slot k, sel SHALL have only bit k low, and seg SHALL be the pattern for snapshot digit k.
REQ-011 sel and seg SHALL be registered; their value in a cycle reflects the slot and phase counters from the previous edge.
REQ-012 All six op inputs SHALL be captured into a snapshot register on the edge where slot 5 ends and slot 0 begins; display SHALL use only the snapshot (no tearing within a frame).
REQ-013 Digit patterns (seg[6:0] with dp off) SHALL be: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90 (hex).
REQ-014 Snapshot digits with value 10..63 SHALL display a dash, 8'hBF.
REQ-015 A blink counter SHALL toggle blink phase every BLINK_HALF cycles, free-running and independent of scanning.
REQ-016 When blink phase is 1, seg[7] SHALL be 0 during the lit cycles of slots 2 and 4 (separators HH.MM.SS); otherwise seg[7] SHALL be 1.
REQ-017 The slot counter SHALL wrap from slot 5, last cycle, to slot 0, first cycle, with no idle cycle.

Reset
REQ-018 While rst_n is low, outputs SHALL be sel=6'h3F and seg=8'hFF; slot=0, phase counter=0, snapshot=all 0, blink counter=0, blink phase=0.
REQ-019 Assertion of rst_n mid-slot SHALL force REQ-018 values immediately, without waiting for a clock edge.
REQ-020 After rst_n deasserts, the first edge SHALL begin slot 0 with its blanking cycle, and the snapshot SHALL be loaded from op inputs on that edge.

Configuration
REQ-021 Macro LEADING_ZERO_BLANK_EN: when defined, a snapshot op5 equal to 0 SHALL make slot 5 show sel=6'h3F and seg=8'hFF for the whole slot.
REQ-022 When LEADING_ZERO_BLANK_EN is undefined, op5=0 SHALL display 8'hC0 normally.

Structure
REQ-023 A shared package/include SHALL hold the segment constants SEG_0..SEG_9, SEG_DASH (8'hBF), SEG_OFF (8'hFF) and SEL_OFF (6'h3F).
REQ-024 Decoding SHALL be a combinational sub-module seg7_decode (6-bit digit in, 7-bit pattern out); scan, snapshot and blink logic SHALL stay in seg_scan_display.

Verification
REQ-025 Reset test: with rst_n low, expect sel=3F and seg=FF. Release rst_n with SCAN_DIV=2; expect cycle 1 blank, then cycle 2 sel=3E with the op0 pattern.
REQ-026 Decode test: set op5..op0 = 1,2,3,4,5,6. Over one frame, expect sel=3E/seg=82, sel=3D/seg=92, sel=3B/seg=99, sel=37/seg=B0, sel=2F/seg=A4, sel=1F/seg=F9 (blink phase 0).
REQ-027 Dash test: set op0=12; slot 0 SHALL show seg=BF.
REQ-028 Snapshot test: change op0 from 3 to 7 during slot 3. The current frame SHALL show nothing new; the next slot 0 SHALL show F8.
REQ-029 Blink test: set BLINK_HALF=4, SCAN_DIV=2. seg[7] SHALL be 0 only in lit cycles of slots 2 and 4, and only during blink phase 1; phase SHALL toggle every 4 cycles.
REQ-030 Leading-zero test: set op5=0. With LEADING_ZERO_BLANK_EN defined, slot 5 SHALL be sel=3F/seg=FF. Without the macro, slot 5 SHALL be sel=1F/seg=C0.
